// File: rtl/divu_seq_pkg.sv
// Shared types and sizing helpers for the sequential unsigned divider.
package divu_seq_pkg;

  // Two-state controller: IDLE waits for start, CALC resolves one quotient bit per edge.
  typedef enum logic {
    StIdle = 1'b0,
    StCalc = 1'b1
  } state_e;

  // Iteration counter must hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/divu_sub_stage.sv
// Combinational ripple-carry subtractor: diff = a - b computed as a + ~b + 1.
module divu_sub_stage #(
  parameter int unsigned WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             no_borrow
);

  logic [WIDTH-1:0] b_n;

  assign b_n = ~b;

  // Single carry variable rippled bit by bit; carry-out of 1 means a >= b.
  always_comb begin
    logic c;
    diff = '0;
    c    = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i] = a[i] ^ b_n[i] ^ c;
      c       = (a[i] & b_n[i]) | (c & (a[i] ^ b_n[i]));
    end
    no_borrow = c;
  end

endmodule

// File: rtl/divu_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock, start/done handshake.
module divu_seq
  import divu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] quot_out_q, quot_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             no_borrow;

  // Partial remainder stays below divisor, so the shift never loses its top bit.
  assign shifted = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};

  divu_sub_stage #(
    .WIDTH(WIDTH + 1)
  ) u_sub (
    .a        (shifted),
    .b        ({1'b0, dvs_q}),
    .diff     (trial),
    .no_borrow(no_borrow)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    quot_out_d = quot_out_q;
    rem_out_d  = rem_out_q;
    dbz_d      = dbz_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCalc;
          cnt_d   = CNT_W'(WIDTH);
          dvd_d   = dividend;
          dvs_d   = divisor;
          rem_d   = '0;
          quo_d   = '0;
        end
      end
      StCalc: begin
        if (dvs_q == '0) begin
          // Zero divisor: finish after one cycle with the all-ones quotient convention.
          state_d    = StIdle;
          cnt_d      = '0;
          quot_out_d = '1;
          rem_out_d  = dvd_q;
          dbz_d      = 1'b1;
          done_d     = 1'b1;
        end else begin
          rem_d = no_borrow ? trial : shifted;
          dvd_d = dvd_q << 1;
          quo_d = {quo_q[WIDTH-2:0], no_borrow};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d    = StIdle;
            quot_out_d = {quo_q[WIDTH-2:0], no_borrow};
            rem_out_d  = no_borrow ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
            dbz_d      = 1'b0;
            done_d     = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
      dbz_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      quot_out_q <= quot_out_d;
      rem_out_q  <= rem_out_d;
      dbz_q      <= dbz_d;
      done_q     <= done_d;
    end
  end

  assign busy        = (state_q == StCalc);
  assign done        = done_q;
  assign quotient    = quot_out_q;
  assign remainder   = rem_out_q;
  assign div_by_zero = dbz_q;

endmodule
